// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if
//   Bundles the requester-side bus and the shared-multiplier bus of
//   booth_mul_arbiter into one interface.
//   slave  : arbiter view (drives gnt/rsp_*/busy/mul_start/mul_a/mul_b)
//   master : environment view (drives req/a_in/b_in/mul_done/mul_p)
//   Signals:
//     req       NREQ      per-requester operation request (level)
//     a_in/b_in NREQ*N    operands, requester i at [i*N +: N]
//     gnt       NREQ      one-hot request-consumed pulse
//     rsp_valid 1         result strobe
//     rsp_id    IDW       owner of the result
//     rsp_data  2N        signed product
//     rsp_err   1         operation timed out
//     busy      1         arbiter not idle
//     mul_start 1         multiplier launch pulse
//     mul_a/b   N         latched operands to the multiplier
//     mul_done  1         multiplier completion
//     mul_p     2N        multiplier product
interface booth_mul_arbiter_if #(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] a_in;
  logic [NREQ*N-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              mul_start;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic              mul_done;
  logic [2*N-1:0]    mul_p;

  modport slave (
    input  req, a_in, b_in, mul_done, mul_p,
    output gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
           mul_start, mul_a, mul_b
  );

  modport master (
    output req, a_in, b_in, mul_done, mul_p,
    input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
           mul_start, mul_a, mul_b
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter
//   Shares one Booth multiplier between NREQ requesters. Round-robin pick in
//   IDLE, operand latch, one-cycle launch, wait for mul_done, then a one-cycle
//   tagged response. The multiplier only ever sees one operation at a time.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    booth_mul_arbiter_if.slave (requester and multiplier signals)
//   Optional feature macro: BOOTH_ARB_TIMEOUT_EN
//     defined   : WAIT is bounded to TIMEOUT cycles, then RESP with rsp_err=1
//                 and rsp_data=0 (a done in the limit cycle still wins)
//     undefined : WAIT waits indefinitely, rsp_err is tied low
module booth_mul_arbiter #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  booth_mul_arbiter_if.slave bus
);

  if (NREQ < 2 || NREQ > 16 || IDW != $clog2(NREQ) ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_cfg_check
    $error("booth_mul_arbiter: unsupported parameter set");
  end

  localparam int unsigned NR = NREQ;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  cur_id;

  logic [NREQ-1:0] gnt_q;
  logic            mul_start_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [2*N-1:0]  rsp_data_q;
  logic            busy_q;
  logic [N-1:0]    mul_a_q;
  logic [N-1:0]    mul_b_q;

  // Round-robin winner: first set request at or above ptr, wrapping.
  logic            found;
  logic [IDW-1:0]  win;
  logic [N-1:0]    win_a;
  logic [N-1:0]    win_b;
  int unsigned     idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    win_a = '0;
    win_b = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NR) idx = idx - NR;
      if (!found && bus.req[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
        win_a = bus.a_in[idx*N +: N];
        win_b = bus.b_in[idx*N +: N];
      end
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wcnt;
  logic        rsp_err_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cur_id      <= '0;
      gnt_q       <= '0;
      mul_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      wcnt        <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      gnt_q       <= '0;
      mul_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            cur_id      <= win;
            mul_a_q     <= win_a;
            mul_b_q     <= win_b;
            gnt_q       <= {{(NREQ-1){1'b0}}, 1'b1} << win;
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
`ifdef BOOTH_ARB_TIMEOUT_EN
          wcnt  <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (bus.mul_done) begin
            rsp_data_q  <= bus.mul_p;
            rsp_id_q    <= cur_id;
            rsp_valid_q <= 1'b1;
`ifdef BOOTH_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state       <= RESP;
          end
`ifdef BOOTH_ARB_TIMEOUT_EN
          // wcnt counts completed WAIT cycles, so WAIT_LAST marks the
          // TIMEOUT-th one.
          else if (wcnt == WAIT_LAST) begin
            rsp_data_q  <= '0;
            rsp_id_q    <= cur_id;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
`endif
        end
        RESP: begin
          ptr    <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.mul_start = mul_start_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign bus.rsp_err   = rsp_err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: doc/booth_mul_arbiter.md
# booth_mul_arbiter

Shares one Booth multiplier (controller + datapath, `mul_start`/`mul_done` contract) between `NREQ` independent requesters. Round-robin grant, operand latch, one-cycle multiplier launch, wait for completion, result returned tagged with the requester index. Sits between the requesting engines and the single multiplier instance; the multiplier sees exactly one operation at a time.

## Interface
- `N`, 8, operand width; product width `2N`
- `NREQ`, 4, requester count (2..16)
- `IDW`, 2, requester index width, `$clog2(NREQ)`
- `TIMEOUT`, 64, watchdog limit in cycles (used only with `BOOTH_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req`  in  NREQ  per-requester operation request, level
- `a_in`  in  NREQ*N  multiplicands, requester i at `[i*N +: N]`
- `b_in`  in  NREQ*N  multipliers, same packing
- `gnt`  out  NREQ  one-hot, one-cycle pulse: request consumed
- `rsp_valid`  out  1  one-cycle result strobe
- `rsp_id`  out  IDW  index of the requester owning the result
- `rsp_data`  out  2N  signed product
- `rsp_err`  out  1  operation timed out (with `rsp_valid`)
- `busy`  out  1  high in any state other than IDLE
- `mul_start`  out  1  one-cycle launch pulse to the multiplier
- `mul_a`, `mul_b`  out  N  latched operands, stable from LAUNCH through RESP
- `mul_done`  in  1  multiplier completion, sampled in WAIT only
- `mul_p`  in  2N  multiplier product, valid while `mul_done` is high

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE: if `req` != 0, winner = first set bit searching from `ptr` upward, wrapping modulo NREQ. Latch the winner's operands into `mul_a`/`mul_b`, latch winner into `cur_id`, go to LAUNCH. If `req` == 0, stay in IDLE.
- LAUNCH: `mul_start`=1 and `gnt[cur_id]`=1 for this cycle only. Next state is WAIT.
- WAIT: when `mul_done`=1, capture `mul_p` into `rsp_data` and go to RESP. `mul_done` is ignored in every other state.
- RESP: `rsp_valid`=1 and `rsp_id`=`cur_id` for one cycle. `ptr` ← `cur_id`+1 (wraps to 0 at NREQ). Next state is IDLE.
- `req` is sampled only in IDLE. A requester holding `req` after its `gnt` is treated as issuing a new operation.
- Fairness: a requester with `req` held continuously waits at most NREQ−1 other operations.
- `rsp_data`, `rsp_id` and `rsp_err` hold their values until the next RESP.
- Reset value of every output is 0. Reset also sets state=IDLE and `ptr`=0.
- Reset mid-operation abandons the operation with no `rsp_valid` and no further `mul_start`.

## Timing
- Request seen in IDLE at edge k: LAUNCH (`gnt`, `mul_start`) in cycle k+1; WAIT from cycle k+2.
- `mul_done` sampled high at edge m (m ≥ k+2): `rsp_valid` in cycle m+1. Earliest `rsp_valid` is cycle k+3.
- Back-to-back: the next IDLE evaluation occurs one cycle after RESP. Per-operation overhead is 3 cycles plus multiplier latency.
- `mul_done` high during LAUNCH does not complete the operation. Only WAIT sampling counts.

## Configuration
- `BOOTH_ARB_TIMEOUT_EN` defined:
  - 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches `TIMEOUT` without `mul_done`, the FSM goes to RESP with `rsp_err`=1 and `rsp_data`=0.
  - `mul_done` and the limit reached in the same cycle: done wins, `rsp_err`=0.
- Not defined: no counter is present, WAIT waits indefinitely, and `rsp_err` is tied to 0.

## Test plan
- Single op: reset, then `req`=0001, a0=7, b0=−3, multiplier model done 10 cycles after start → `gnt`=0001 once, `mul_start` once, `rsp_valid` once with `rsp_id`=0, `rsp_data`=−21, `rsp_err`=0.
- Round-robin: `req`=1111 held for 8 ops → `rsp_id` sequence 0,1,2,3,0,1,2,3, with exactly one `gnt` per op.
- Wrap and skip: `ptr`=3, `req`=0101 → winner 0, then 2. Signed extremes: a=−128, b=−128 at N=8 → `rsp_data`=16384.
- Early done: `mul_done` forced high during LAUNCH and low in the first WAIT cycle, then high 5 cycles later → result captured only on the later assertion.
- Reset mid-WAIT: deassert `rst_n` for one cycle → all outputs 0 next cycle, no `rsp_valid`. Then `req`=0010 → served normally starting from `ptr`=0.
- Timeout (`BOOTH_ARB_TIMEOUT_EN`, `TIMEOUT`=64): `mul_done` never asserted → `rsp_valid` with `rsp_err`=1 and `rsp_data`=0 exactly 64 WAIT cycles after LAUNCH. The next request proceeds normally.
